alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor to the team's 8-bit combinational ALU; sits between the register file and the accumulator/result bus of the datapath.
- Extends the opcode field to 4 bits and adds carry-chained add/subtract, compare, iterative shifts and an iterative shift-add multiply.
- Holds registered status flags: Z, C, V, N.
- A start/busy/done handshake covers both single-cycle and multi-cycle operations.

Parameters:
- WIDTH, 8, operand and result width in bits (must be ≥2 and a power of 2).
- CW, $clog2(WIDTH), derived shift-count width; do not override.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; A, B and Op are sampled when start=1 and busy=0
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B (bits [CW-1:0] give the shift count for shift ops)
- Op  input  4  operation select
- S  output  WIDTH  registered result
- zero  output  1  Z flag
- carry  output  1  C flag
- ovf  output  1  V flag (signed overflow)
- neg  output  1  N flag (S[WIDTH-1])
- busy  output  1  high while a multi-cycle operation is in progress
- done  output  1  one-cycle pulse when S and the flags have been updated

Behaviour:
- Reset (asynchronous, reset_n=0): S=0, zero=1, carry=0, ovf=0, neg=0, busy=0, done=0, FSM goes to IDLE. Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, SHIFT, MUL.
  - IDLE: on start, latch A, B and Op.
    - Single-cycle op: S and flags update at that same edge, done=1 for the next cycle, FSM stays in IDLE (latency 1).
    - Shift op with count n>0: go to SHIFT, busy=1.
    - Shift op with count n=0: complete as a single-cycle op; S=A, C unchanged.
    - MUL: go to MUL, busy=1.
  - SHIFT: shift the working register 1 bit per cycle and decrement the count. On count==0, write S and flags, set busy=0, pulse done, return to IDLE. done is asserted n+1 cycles after the start edge.
  - MUL: shift-add using a CW+1-bit iteration counter. WIDTH iterations, then write back. done is asserted WIDTH+1 cycles after the start edge.
- start is ignored while busy=1; inputs may change freely during that time.
- done is never asserted in the same cycle as busy=1.
- Opcodes (all arithmetic is modulo 2^WIDTH):
  - 0000 S=A
  - 0001 S=~A
  - 0010 S=A+B
  - 0011 S=A-B
  - 0100 S=A&B
  - 0101 S=A|B
  - 0110 S=-A
  - 0111 S=-B
  - 1000 S=A^B
  - 1001 ADC: S=A+B+C
  - 1010 SBC: S=A-B-C
  - 1011 SHL, logical left by n
  - 1100 SHR, logical right by n
  - 1101 SAR, arithmetic right by n
  - 1110 MUL: S = low WIDTH bits of A*B (unsigned)
  - 1111 CMP: flags from A-B; S unchanged
- Flag rules (flags update only at write-back, together with S):
  - Z = (result==0). For CMP, Z is computed from the A-B difference, not from S.
  - N = result MSB.
  - Add ops (0010, 1001): C = carry-out; V = signed overflow.
  - Subtract ops (0011, 1010, 1111, 0110, 0111): C = borrow (1 when the unsigned minuend < subtrahend + borrow-in); V = signed overflow. Negate ops are treated as 0-operand: C=1 unless the operand is 0; V=1 only for the most-negative value.
  - Logic and move ops (0000, 0001, 0100, 0101, 1000): C preserved, V=0.
  - Shifts: C = last bit shifted out; V=0.
  - MUL: C=1 if the high WIDTH bits of the full product are nonzero; V=0.
- Outputs are stable between write-backs; S and flags hold their values while IDLE or busy.

Test Plan:
- Reset release, then start Op=0010, A=8'h7F, B=8'h01 -> one cycle later S=8'h80, done=1, Z=0, N=1, V=1, C=0.
- Op=0010, A=8'hFF, B=8'h01, then Op=1001, A=8'h00, B=8'h00 -> first result S=00, Z=1, C=1; ADC result S=8'h01, C=0.
- Op=1111, A=8'h05, B=8'h07 with S previously 8'h01 -> S stays 8'h01, C=1, N=1, Z=0, V=0, latency 1.
- Op=1101, A=8'h90, B=8'h03 -> busy high for 3 cycles, done on cycle 4, S=8'hF2, C=0. Same with B=0 -> S=8'h90 after 1 cycle, C unchanged.
- Op=1110, A=8'h12, B=8'h10 -> done 9 cycles after start, S=8'h20, C=1. Second start issued while busy with Op=0000 -> ignored, result unaffected.
- Start MUL, assert reset_n=0 at cycle 4 -> outputs return to reset values immediately, no done pulse. Next op (Op=0000, A=8'h3C) completes normally with S=8'h3C.

Source files
------------

// File: rtl/alu_seq.sv
// Clocked ALU with registered Z/C/V/N flags and a start/busy/done handshake.
// Shifts run one bit per cycle and multiply is an iterative shift-add.
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  output logic [WIDTH-1:0] S,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             neg,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OpMov  = 4'h0;
  localparam logic [3:0] OpNot  = 4'h1;
  localparam logic [3:0] OpAdd  = 4'h2;
  localparam logic [3:0] OpSub  = 4'h3;
  localparam logic [3:0] OpAnd  = 4'h4;
  localparam logic [3:0] OpOr   = 4'h5;
  localparam logic [3:0] OpNegA = 4'h6;
  localparam logic [3:0] OpNegB = 4'h7;
  localparam logic [3:0] OpXor  = 4'h8;
  localparam logic [3:0] OpAdc  = 4'h9;
  localparam logic [3:0] OpSbc  = 4'hA;
  localparam logic [3:0] OpShl  = 4'hB;
  localparam logic [3:0] OpShr  = 4'hC;
  localparam logic [3:0] OpSar  = 4'hD;
  localparam logic [3:0] OpMul  = 4'hE;
  localparam logic [3:0] OpCmp  = 4'hF;

  localparam logic [CW:0] CntOne = {{CW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StShift, StMul} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     s_q, s_d;
  logic                 zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, neg_q, neg_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CW:0]          cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;

  // Datapath helpers
  logic [WIDTH:0]       add_r, sub_r;
  logic [WIDTH-1:0]     sub_x, sub_y;
  logic                 add_cin, sub_bin, add_v, sub_v;
  logic [WIDTH-1:0]     sh_val;
  logic                 sh_out;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod_nx;

  // Write-back request
  logic                 wb, wb_keep_s, wb_c, wb_v;
  logic [WIDTH-1:0]     wb_val;

  always_comb begin
    add_cin = (Op == OpAdc) & carry_q;
    add_r   = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, add_cin};
    add_v   = (A[WIDTH-1] == B[WIDTH-1]) & (add_r[WIDTH-1] != A[WIDTH-1]);

    // Negates reuse the subtractor with a zero minuend.
    sub_x   = A;
    sub_y   = B;
    sub_bin = (Op == OpSbc) & carry_q;
    if (Op == OpNegA) begin
      sub_x = '0;
      sub_y = A;
    end else if (Op == OpNegB) begin
      sub_x = '0;
      sub_y = B;
    end
    sub_r = {1'b0, sub_x} - {1'b0, sub_y} - {{WIDTH{1'b0}}, sub_bin};
    sub_v = (sub_x[WIDTH-1] != sub_y[WIDTH-1]) & (sub_r[WIDTH-1] != sub_x[WIDTH-1]);
  end

  always_comb begin
    case (op_q)
      OpShl: begin
        sh_val = {work_q[WIDTH-2:0], 1'b0};
        sh_out = work_q[WIDTH-1];
      end
      OpShr: begin
        sh_val = {1'b0, work_q[WIDTH-1:1]};
        sh_out = work_q[0];
      end
      default: begin
        sh_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        sh_out = work_q[0];
      end
    endcase

    // Product register: high half accumulates, low half holds the unused multiplier bits.
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    prod_nx = {mul_sum, prod_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    work_d    = work_q;
    a_d       = a_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    wb        = 1'b0;
    wb_keep_s = 1'b0;
    wb_val    = '0;
    wb_c      = carry_q;
    wb_v      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d = Op;
          case (Op)
            OpMov: begin wb = 1'b1; wb_val = A;     end
            OpNot: begin wb = 1'b1; wb_val = ~A;    end
            OpAnd: begin wb = 1'b1; wb_val = A & B; end
            OpOr:  begin wb = 1'b1; wb_val = A | B; end
            OpXor: begin wb = 1'b1; wb_val = A ^ B; end
            OpAdd, OpAdc: begin
              wb     = 1'b1;
              wb_val = add_r[WIDTH-1:0];
              wb_c   = add_r[WIDTH];
              wb_v   = add_v;
            end
            OpSub, OpSbc, OpNegA, OpNegB, OpCmp: begin
              wb        = 1'b1;
              wb_keep_s = (Op == OpCmp);
              wb_val    = sub_r[WIDTH-1:0];
              wb_c      = sub_r[WIDTH];
              wb_v      = sub_v;
            end
            OpShl, OpShr, OpSar: begin
              if (B[CW-1:0] == '0) begin
                wb     = 1'b1;
                wb_val = A;
              end else begin
                state_d = StShift;
                work_d  = A;
                cnt_d   = {1'b0, B[CW-1:0]};
              end
            end
            OpMul: begin
              state_d = StMul;
              a_d     = A;
              prod_d  = {{WIDTH{1'b0}}, B};
              cnt_d   = (CW+1)'(WIDTH);
            end
            default: ;
          endcase
        end
      end
      StShift: begin
        work_d = sh_val;
        cnt_d  = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          wb      = 1'b1;
          wb_val  = sh_val;
          wb_c    = sh_out;
          state_d = StIdle;
        end
      end
      StMul: begin
        prod_d = prod_nx;
        cnt_d  = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          wb      = 1'b1;
          wb_val  = prod_nx[WIDTH-1:0];
          wb_c    = |prod_nx[2*WIDTH-1:WIDTH];
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wb) begin
      done_d  = 1'b1;
      zero_d  = (wb_val == '0);
      neg_d   = wb_val[WIDTH-1];
      carry_d = wb_c;
      ovf_d   = wb_v;
      if (!wb_keep_s) s_d = wb_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      work_q  <= '0;
      a_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      work_q  <= work_d;
      a_q     <= a_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign S     = s_q;
  assign zero  = zero_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;
  assign neg   = neg_q;
  assign busy  = (state_q != StIdle);
  assign done  = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq (WIDTH=8) against an integer-arithmetic reference model.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] A, B;
  logic [3:0] Op;
  logic [7:0] S;
  logic       zero, carry, ovf, neg, busy, done;

  int n_vec = 0;
  int n_err = 0;

  // Reference architectural state
  int m_s;
  bit m_z, m_c, m_v, m_n;

  alu_seq #(.WIDTH(8)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .A      (A),
    .B      (B),
    .Op     (Op),
    .S      (S),
    .zero   (zero),
    .carry  (carry),
    .ovf    (ovf),
    .neg    (neg),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic sub_m(input int x, input int y, input int bin,
                       output int r, output bit c, output bit v);
    int d;
    r = (((x - y - bin) % 256) + 256) % 256;
    c = (x < y + bin);
    d = sgn(x) - sgn(y) - bin;
    v = (d > 127) || (d < -128);
  endtask

  task automatic model_reset();
    m_s = 0; m_z = 1; m_c = 0; m_v = 0; m_n = 0;
  endtask

  // Updates the model and returns cycles from start edge to visible done.
  task automatic model(input int op, input int a, input int b, output int lat);
    int r, t, n, sa, sb;
    bit c, v, keep;
    sa = sgn(a); sb = sgn(b);
    n = b % 8; lat = 1; c = m_c; v = 0; keep = 0; r = 0;
    case (op)
      0:  r = a;
      1:  r = 255 - a;
      2, 9: begin
        t = a + b + ((op == 9) ? int'(m_c) : 0);
        r = t % 256; c = (t > 255);
        t = sa + sb + ((op == 9) ? int'(m_c) : 0);
        v = (t > 127) || (t < -128);
      end
      3:  sub_m(a, b, 0, r, c, v);
      10: sub_m(a, b, int'(m_c), r, c, v);
      6:  sub_m(0, a, 0, r, c, v);
      7:  sub_m(0, b, 0, r, c, v);
      15: begin sub_m(a, b, 0, r, c, v); keep = 1; end
      4:  r = a & b;
      5:  r = a | b;
      8:  r = a ^ b;
      11: begin r = (a << n) % 256; if (n > 0) c = ((a >> (8 - n)) & 1) != 0; end
      12: begin r = a >> n; if (n > 0) c = ((a >> (n - 1)) & 1) != 0; end
      13: begin r = (sa >>> n) & 255; if (n > 0) c = ((sa >>> (n - 1)) & 1) != 0; end
      14: begin t = a * b; r = t % 256; c = (t > 255); end
      default: ;
    endcase
    if (op inside {11, 12, 13}) lat = n + 1;
    if (op == 14) lat = 9;
    m_z = (r == 0); m_n = (r >= 128); m_c = c; m_v = v;
    if (!keep) m_s = r;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit poke);
    int exp_lat, lat;
    model(int'(op), int'(a), int'(b), exp_lat);
    @(negedge clk);
    start = 1'b1; Op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 1 && exp_lat > 1) check("busy", 32'(busy), 32'd1);
      // A start while busy must be ignored.
      if (poke && lat == 1) begin
        start = 1'b1; Op = 4'h0; A = ~a; B = 8'h5A;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check($sformatf("lat op%0h", op), 32'(lat), 32'(exp_lat));
    check("busy_at_done", 32'(busy), 32'd0);
    check($sformatf("S op%0h", op), 32'(S), 32'(m_s));
    check($sformatf("ZCVN op%0h", op), {28'd0, zero, carry, ovf, neg},
          {28'd0, m_z, m_c, m_v, m_n});
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; A = '0; B = '0; Op = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst S", 32'(S), 32'd0);
    check("rst ZCVN", {28'd0, zero, carry, ovf, neg}, 32'b1000);
    check("rst busy/done", {30'd0, busy, done}, 32'd0);
    reset_n = 1'b1;

    run_op(4'h2, 8'h7F, 8'h01, 1'b0);
    check("tp add S", 32'(S), 32'h80);
    run_op(4'h2, 8'hFF, 8'h01, 1'b0);
    run_op(4'h9, 8'h00, 8'h00, 1'b0);
    check("tp adc S", 32'(S), 32'h01);
    run_op(4'hF, 8'h05, 8'h07, 1'b0);
    check("tp cmp ZCVN", {28'd0, zero, carry, ovf, neg}, 32'b0101);
    run_op(4'hD, 8'h90, 8'h03, 1'b0);
    check("tp sar S", 32'(S), 32'hF2);
    run_op(4'hD, 8'h90, 8'h00, 1'b0);
    run_op(4'hE, 8'h12, 8'h10, 1'b1);
    check("tp mul S", 32'(S), 32'h20);
    run_op(4'h6, 8'h80, 8'h00, 1'b0);
    run_op(4'h7, 8'h00, 8'h00, 1'b0);
    run_op(4'hB, 8'h81, 8'h07, 1'b1);

    // Reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; Op = 4'hE; A = 8'hFF; B = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("midrst S", 32'(S), 32'd0);
    check("midrst ZCVN", {28'd0, zero, carry, ovf, neg}, 32'b1000);
    check("midrst busy/done", {30'd0, busy, done}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("midrst no done", 32'(done), 32'd0);
    end
    reset_n = 1'b1;
    run_op(4'h0, 8'h3C, 8'h00, 1'b0);
    check("tp after rst S", 32'(S), 32'h3C);

    for (int i = 0; i < 150; i++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
